// File: rtl/rc_pwm_gen.sv
// rtl/rc_pwm_gen.sv - six-channel RC PWM pulse generator
// Widths and enable mask are double-buffered and applied only at frame wrap.
module rc_pwm_gen #(
  parameter int CLK_MHZ    = 50,
  parameter int FRAME_US   = 20000,
  parameter int MIN_US     = 800,
  parameter int MAX_US     = 2200,
  parameter int DEFAULT_US = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] in_data,
  input  logic        in_wr,
  output logic [5:0]  rc_out,
  output logic        frame_stb
);

  localparam int              PS_W       = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(CLK_MHZ - 1);
  localparam logic [15:0]     FRAME_LAST = 16'(FRAME_US - 1);
  localparam logic [15:0]     MIN_W      = 16'(MIN_US);
  localparam logic [15:0]     MAX_W      = 16'(MAX_US);
  localparam logic [15:0]     DEF_W      = 16'(DEFAULT_US);
  localparam logic [2:0]      CMD_EN     = 3'd7;

  function automatic logic [15:0] clamp_w(input logic [15:0] v);
    if (v == 16'd0)     clamp_w = 16'd0;
    else if (v < MIN_W) clamp_w = MIN_W;
    else if (v > MAX_W) clamp_w = MAX_W;
    else                clamp_w = v;
  endfunction

  logic [PS_W-1:0] ps_q, ps_d;
  logic [15:0]     us_cnt_q, us_cnt_d;
  logic [15:0]     shadow_w_q [6];
  logic [15:0]     shadow_w_d [6];
  logic [15:0]     active_w_q [6];
  logic [15:0]     active_w_d [6];
  logic [5:0]      shadow_en_q, shadow_en_d;
  logic [5:0]      active_en_q, active_en_d;
  logic [5:0]      rc_out_q, rc_out_d;
  logic            frame_stb_q, frame_stb_d;
  logic            tick, wrap;
  logic [2:0]      cmd;
  logic            unused_bits;

  assign cmd         = in_data[23:21];
  assign unused_bits = ^in_data[20:16];
  assign tick        = (ps_q == PS_LAST);
  assign wrap        = tick && (us_cnt_q == FRAME_LAST);

  always_comb begin
    ps_d        = tick ? '0 : ps_q + 1'b1;
    us_cnt_d    = us_cnt_q;
    if (tick) us_cnt_d = (us_cnt_q == FRAME_LAST) ? 16'd0 : us_cnt_q + 16'd1;

    shadow_en_d = shadow_en_q;
    for (int i = 0; i < 6; i++) shadow_w_d[i] = shadow_w_q[i];
    if (in_wr) begin
      if (cmd == CMD_EN) shadow_en_d = in_data[5:0];
      for (int i = 0; i < 6; i++)
        if (cmd == 3'(i)) shadow_w_d[i] = clamp_w(in_data[15:0]);
    end

    // A write landing in the wrap cycle only reaches the shadow, so it waits a frame.
    active_en_d = wrap ? shadow_en_q : active_en_q;
    for (int i = 0; i < 6; i++) active_w_d[i] = wrap ? shadow_w_q[i] : active_w_q[i];

    // Outputs are driven from next-state values so the rising edge coincides with frame_stb.
    for (int i = 0; i < 6; i++) rc_out_d[i] = active_en_d[i] && (us_cnt_d < active_w_d[i]);
    frame_stb_d = wrap;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q        <= '0;
      us_cnt_q    <= 16'd0;
      shadow_en_q <= 6'd0;
      active_en_q <= 6'd0;
      rc_out_q    <= 6'd0;
      frame_stb_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_w_q[i] <= DEF_W;
        active_w_q[i] <= 16'd0;
      end
    end else begin
      ps_q        <= ps_d;
      us_cnt_q    <= us_cnt_d;
      shadow_en_q <= shadow_en_d;
      active_en_q <= active_en_d;
      rc_out_q    <= rc_out_d;
      frame_stb_q <= frame_stb_d;
      for (int i = 0; i < 6; i++) begin
        shadow_w_q[i] <= shadow_w_d[i];
        active_w_q[i] <= active_w_d[i];
      end
    end
  end

  assign rc_out    = rc_out_q;
  assign frame_stb = frame_stb_q;

endmodule

// File: tb/tb_rc_pwm_gen.sv
// tb/tb_rc_pwm_gen.sv - self-checking bench for rc_pwm_gen
// Frame-level reference model plus directed scenarios and a random soak.
module tb_rc_pwm_gen;
  localparam int C  = 2;
  localparam int F  = 100;
  localparam int FC = C * F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] in_data = 24'd0;
  logic        in_wr = 1'b0;
  logic [5:0]  rc_out;
  logic        frame_stb;

  rc_pwm_gen #(.CLK_MHZ(C), .FRAME_US(F), .MIN_US(10), .MAX_US(50), .DEFAULT_US(30)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_wr(in_wr),
    .rc_out(rc_out), .frame_stb(frame_stb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: n counts clock edges since reset release; frame position is n mod FC
  int       m_n;
  int       m_sw [6];
  int       m_aw [6];
  logic [5:0] m_sen, m_aen;
  int       hi [6];
  int       stb_cnt;

  typedef struct {int ch; int val; int exp_hi;} vec_t;
  vec_t tbl [6];

  function automatic int clampv(input int v);
    if (v == 0) return 0;
    if (v < 10) return 10;
    if (v > 50) return 50;
    return v;
  endfunction

  function automatic logic [23:0] wr_w(input int ch, input int val);
    return {3'(ch), 5'd0, 16'(val)};
  endfunction

  function automatic logic [23:0] wr_en(input int m);
    return {3'd7, 15'd0, 6'(m)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic wr, input logic [23:0] d);
    int c;
    if (r) begin
      m_n = 0;
      m_sen = 6'd0;
      m_aen = 6'd0;
      for (int i = 0; i < 6; i++) begin m_sw[i] = 30; m_aw[i] = 0; end
    end else begin
      m_n++;
      if (m_n % FC == 0) begin
        m_aen = m_sen;
        for (int i = 0; i < 6; i++) m_aw[i] = m_sw[i];
      end
      if (wr) begin
        c = int'(d[23:21]);
        if (c < 6) m_sw[c] = clampv(int'(d[15:0]));
        else if (c == 7) m_sen = d[5:0];
      end
    end
  endtask

  task automatic cyc(input logic wr, input logic [23:0] d);
    logic [5:0] exp_rc;
    in_wr   = wr;
    in_data = d;
    @(posedge clk);
    model_edge(rst, wr, d);
    #1;
    for (int i = 0; i < 6; i++) exp_rc[i] = m_aen[i] && ((m_n % FC) < 2 * m_aw[i]);
    check("rc_out_model", int'(rc_out), int'(exp_rc));
    check("frame_stb_model", int'(frame_stb), int'(m_n > 0 && m_n % FC == 0));
    for (int i = 0; i < 6; i++) if (rc_out[i]) hi[i]++;
    if (frame_stb) stb_cnt++;
    in_wr = 1'b0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 6; i++) hi[i] = 0;
    stb_cnt = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 24'd0);
  endtask

  task automatic to_pre_wrap();
    for (int k = 0; k < FC && (m_n % FC) != FC - 1; k++) cyc(1'b0, 24'd0);
  endtask

  task automatic frame();
    clear_counts();
    idle(FC);
  endtask

  function automatic int hi_sum();
    int s = 0;
    for (int i = 0; i < 6; i++) s += hi[i];
    return s;
  endfunction

  initial begin
    tbl[0] = '{0, 5, 20};
    tbl[1] = '{1, 70, 100};
    tbl[2] = '{2, 0, 0};
    tbl[3] = '{3, 25, 50};
    tbl[4] = '{4, 45, 0};
    tbl[5] = '{5, 1, 0};

    // reset and defaults; a write during reset must be ignored
    rst = 1'b1;
    cyc(1'b0, 24'd0);
    cyc(1'b1, wr_en(6'h3F));
    check("reset_rc_out", int'(rc_out), 0);
    check("reset_frame_stb", int'(frame_stb), 0);
    rst = 1'b0;
    clear_counts();
    cyc(1'b1, wr_en(6'h3F));
    idle(FC - 2);
    check("s1_first_frame_silent", hi_sum(), 0);
    check("s1_first_frame_no_stb", stb_cnt, 0);
    for (int f = 0; f < 2; f++) begin
      frame();
      for (int i = 0; i < 6; i++) check($sformatf("s1_f%0d_ch%0d_width", f, i), hi[i], 60);
      check($sformatf("s1_f%0d_stb", f), stb_cnt, 1);
    end

    // clamping, table-driven
    foreach (tbl[k]) cyc(1'b1, wr_w(tbl[k].ch, tbl[k].val));
    cyc(1'b1, wr_en(6'h0F));
    to_pre_wrap();
    frame();
    foreach (tbl[k]) check($sformatf("s2_clamp_ch%0d_v%0d", tbl[k].ch, tbl[k].val), hi[tbl[k].ch], tbl[k].exp_hi);

    // double-buffering: mid-pulse width change waits for the next frame
    cyc(1'b1, wr_w(0, 30));
    cyc(1'b1, wr_en(6'h01));
    to_pre_wrap();
    frame();
    check("s3_base_width", hi[0], 60);
    clear_counts();
    idle(20);
    cyc(1'b1, wr_w(0, 40));
    idle(FC - 21);
    check("s3_current_pulse", hi[0], 60);
    frame();
    check("s3_next_pulse", hi[0], 80);

    // wrap-cycle write collision
    cyc(1'b1, wr_en(6'h02));
    to_pre_wrap();
    clear_counts();
    cyc(1'b1, wr_w(1, 20));
    idle(FC - 1);
    check("s4_wrap_write_old_width", hi[1], 100);
    check("s4_wrap_write_ch0_masked", hi[0], 0);
    frame();
    check("s4_new_width", hi[1], 40);

    // disable mid-pulse, then ignored cmd 6
    clear_counts();
    idle(10);
    cyc(1'b1, wr_en(6'h00));
    idle(FC - 11);
    check("s5_pulse_completes", hi[1], 40);
    frame();
    check("s5_silent_after_disable", hi_sum(), 0);
    check("s5_stb_while_silent", stb_cnt, 1);
    cyc(1'b1, 24'hDF_FFFF);
    cyc(1'b1, 24'hC0_0000);
    to_pre_wrap();
    frame();
    check("s5_cmd6_no_enable", hi_sum(), 0);
    cyc(1'b1, wr_en(6'h02));
    to_pre_wrap();
    frame();
    check("s5_cmd6_width_kept", hi[1], 40);

    // reset mid-pulse
    to_pre_wrap();
    idle(5);
    check("s6_pulse_high_before_rst", int'(rc_out[1]), 1);
    rst = 1'b1;
    cyc(1'b0, 24'd0);
    check("s6_rc_out_after_rst", int'(rc_out), 0);
    cyc(1'b1, wr_w(0, 11));
    rst = 1'b0;
    clear_counts();
    cyc(1'b1, wr_en(6'h3F));
    idle(FC - 2);
    check("s6_first_frame_silent", hi_sum(), 0);
    frame();
    for (int i = 0; i < 6; i++) check($sformatf("s6_ch%0d_default_width", i), hi[i], 60);
    check("s6_stb", stb_cnt, 1);

    // random soak against the model
    for (int k = 0; k < 6000; k++) begin
      logic [23:0] d;
      logic        w;
      w = ($urandom_range(0, 7) == 0);
      d = 24'($urandom);
      if ($urandom_range(0, 3) != 0) d[15:0] = 16'($urandom_range(0, 70));
      if ($urandom_range(0, 2999) == 0) rst = 1'b1;
      cyc(w, d);
      rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
